// File: rtl/fft_peak_finder.sv
// Post-FFT peak search: scans bins MIN_BIN..N/2-1 and reports the largest re^2+im^2.
// Optional PEAK_THRESH_EN adds a threshold input; weak maxima then report bin 0.
module fft_peak_finder #(
    parameter int bit_width = 16,
    parameter int M         = 9,
    parameter int N         = 512,
    parameter int MIN_BIN   = 1,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic [2*bit_width-1:0] wd,
`ifdef PEAK_THRESH_EN
    input  logic [2*bit_width-1:0] threshold,
`endif
    output logic [M-1:0]           rd_adr,
    output logic                   busy,
    output logic                   peak_valid,
    output logic [M-1:0]           peak_bin,
    output logic [2*bit_width-1:0] peak_mag,
    output logic                   frame_release
);

    localparam int W2  = 2 * bit_width;
    localparam int DCW = $clog2(RD_LAT + 3);
    localparam logic [M-1:0]   FIRST = M'(MIN_BIN);
    localparam logic [M-1:0]   LAST  = M'(N / 2 - 1);
    localparam logic [DCW-1:0] DLAST = DCW'(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        REPORT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic           r_done_q;
    logic           r_done_qq;
    logic           w_rise;
    logic           w_start;
    logic           w_report;
    logic [M-1:0]   r_adr;
    logic [DCW-1:0] r_drain_cnt;

    logic           r_tag_v   [RD_LAT];
    logic [M-1:0]   r_tag_bin [RD_LAT];

    logic signed [bit_width-1:0] w_re;
    logic signed [bit_width-1:0] w_im;
    logic signed [W2-1:0]        w_re_x;
    logic signed [W2-1:0]        w_im_x;
    logic signed [W2-1:0]        r_re2;
    logic signed [W2-1:0]        r_im2;
    logic                        r_s1_v;
    logic [M-1:0]                r_s1_bin;
    logic [W2-1:0]               r_sum;
    logic                        r_s2_v;
    logic [M-1:0]                r_s2_bin;

    logic [W2-1:0] r_max_mag;
    logic [M-1:0]  r_max_bin;
    logic          w_upd;
    logic [W2-1:0] w_max_mag;
    logic [M-1:0]  w_max_bin;
    logic [M-1:0]  w_bin_out;

    // Two-flop sample of fft_done: a held level never looks like a new edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done_q  <= 1'b0;
            r_done_qq <= 1'b0;
        end else begin
            r_done_q  <= fft_done;
            r_done_qq <= r_done_q;
        end
    end

    assign w_rise   = r_done_q & ~r_done_qq;
    assign w_start  = (r_state == IDLE) && w_rise;
    assign w_report = (w_next == REPORT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_rise) w_next = SCAN;
            end
            SCAN: begin
                if (!r_done_q)         w_next = IDLE;
                else if (r_adr == LAST) w_next = DRAIN;
            end
            DRAIN: begin
                if (!r_done_q)               w_next = IDLE;
                else if (r_drain_cnt == DLAST) w_next = REPORT;
            end
            REPORT: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adr <= '0;
        end else begin
            unique case (w_next)
                SCAN:    r_adr <= (r_state == SCAN) ? r_adr + M'(1) : FIRST;
                DRAIN:   r_adr <= r_adr;
                default: r_adr <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 r_drain_cnt <= '0;
        else if (r_state == DRAIN)  r_drain_cnt <= r_drain_cnt + DCW'(1);
        else                        r_drain_cnt <= '0;
    end

    // Bin tag follows the RAM read latency so it lines up with wd
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_v[i]   <= 1'b0;
                r_tag_bin[i] <= '0;
            end
        end else if (w_start) begin
            for (int i = 0; i < RD_LAT; i++) r_tag_v[i] <= 1'b0;
        end else begin
            r_tag_v[0]   <= (r_state == SCAN);
            r_tag_bin[0] <= r_adr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_bin[i] <= r_tag_bin[i-1];
            end
        end
    end

    assign w_re   = wd[W2-1:bit_width];
    assign w_im   = wd[bit_width-1:0];
    assign w_re_x = {{bit_width{w_re[bit_width-1]}}, w_re};
    assign w_im_x = {{bit_width{w_im[bit_width-1]}}, w_im};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_re2    <= '0;
            r_im2    <= '0;
            r_s1_v   <= 1'b0;
            r_s1_bin <= '0;
            r_sum    <= '0;
            r_s2_v   <= 1'b0;
            r_s2_bin <= '0;
        end else begin
            r_re2    <= w_re_x * w_re_x;
            r_im2    <= w_im_x * w_im_x;
            r_s1_v   <= w_start ? 1'b0 : r_tag_v[RD_LAT-1];
            r_s1_bin <= r_tag_bin[RD_LAT-1];
            r_sum    <= W2'(unsigned'(r_re2)) + W2'(unsigned'(r_im2));
            r_s2_v   <= w_start ? 1'b0 : r_s1_v;
            r_s2_bin <= r_s1_bin;
        end
    end

    // Strict compare: equal magnitudes keep the earlier (lower) bin
    assign w_upd     = r_s2_v && (r_sum > r_max_mag);
    assign w_max_mag = w_upd ? r_sum : r_max_mag;
    assign w_max_bin = w_upd ? r_s2_bin : r_max_bin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_max_mag <= '0;
            r_max_bin <= '0;
        end else if (w_start) begin
            r_max_mag <= '0;
            r_max_bin <= FIRST;
        end else begin
            r_max_mag <= w_max_mag;
            r_max_bin <= w_max_bin;
        end
    end

`ifdef PEAK_THRESH_EN
    assign w_bin_out = (w_max_mag < threshold) ? '0 : w_max_bin;
`else
    assign w_bin_out = w_max_bin;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_valid    <= 1'b0;
            frame_release <= 1'b0;
            peak_bin      <= '0;
            peak_mag      <= '0;
        end else begin
            peak_valid    <= w_report;
            frame_release <= w_report;
            if (w_report) begin
                peak_bin <= w_bin_out;
                peak_mag <= w_max_mag;
            end
        end
    end

    assign rd_adr = r_adr;
    assign busy   = (r_state == SCAN) || (r_state == DRAIN);

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder: table of spectra plus held-level,
// abort and mid-scan reset sequences against a 1-cycle-latency result RAM model.
module tb_fft_peak_finder;

    logic        clk = 1'b0;
    logic        reset;
    logic        fft_done;
    logic [31:0] wd;
    logic [8:0]  rd_adr;
    logic        busy;
    logic        peak_valid;
    logic [8:0]  peak_bin;
    logic [31:0] peak_mag;
    logic        frame_release;
`ifdef PEAK_THRESH_EN
    logic [31:0] threshold = '0;
`endif

    logic [31:0] mem [512];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        int          idx [3];
        int          re  [3];
        int          im  [3];
        int          exp_bin;
        logic [31:0] exp_mag;
    } vec_t;

    vec_t vecs [6];

    fft_peak_finder dut (
        .clk          (clk),
        .reset        (reset),
        .fft_done     (fft_done),
        .wd           (wd),
`ifdef PEAK_THRESH_EN
        .threshold    (threshold),
`endif
        .rd_adr       (rd_adr),
        .busy         (busy),
        .peak_valid   (peak_valid),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .frame_release(frame_release)
    );

    always #5 clk = ~clk;

    // FFT result RAM: data for address of cycle t appears in cycle t+1
    always @(posedge clk) wd <= mem[rd_adr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = '0;
    endtask

    task automatic set_bin(input int idx, input int re, input int im);
        logic [15:0] r16;
        logic [15:0] i16;
        r16 = 16'(re);
        i16 = 16'(im);
        if (idx >= 0) mem[idx] = {r16, i16};
    endtask

    task automatic set_vec(input int k, input string nm,
                           input int i0, input int r0, input int m0,
                           input int i1, input int r1, input int m1,
                           input int i2, input int r2, input int m2,
                           input int eb, input logic [31:0] em);
        vecs[k].name    = nm;
        vecs[k].idx[0]  = i0; vecs[k].re[0] = r0; vecs[k].im[0] = m0;
        vecs[k].idx[1]  = i1; vecs[k].re[1] = r1; vecs[k].im[1] = m1;
        vecs[k].idx[2]  = i2; vecs[k].re[2] = r2; vecs[k].im[2] = m2;
        vecs[k].exp_bin = eb;
        vecs[k].exp_mag = em;
    endtask

    task automatic quiesce();
        @(negedge clk);
        fft_done = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Raise fft_done and return just after the SCAN-entry edge
    task automatic start_scan(input string nm);
        @(negedge clk);
        fft_done = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({nm, "_busy_entry"}, 32'(busy), 32'd1);
        chk({nm, "_adr_entry"}, 32'(rd_adr), 32'd1);
    endtask

    task automatic run_frame(input string nm, input int exp_bin,
                             input logic [31:0] exp_mag);
        int cyc;
        bit seen;
        start_scan(nm);
        cyc  = 0;
        seen = 0;
        while (cyc < 400 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            if (peak_valid) seen = 1;
        end
        chk({nm, "_seen"}, 32'(seen), 32'd1);
        chk({nm, "_latency"}, 32'(cyc), 32'd258);
        chk({nm, "_bin"}, 32'(peak_bin), 32'(exp_bin));
        chk({nm, "_mag"}, peak_mag, exp_mag);
        chk({nm, "_release"}, 32'(frame_release), 32'd1);
        chk({nm, "_busy_rpt"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_pulse_end"}, 32'({peak_valid, frame_release}), 32'd0);
    endtask

    initial begin
        int cnt;
        reset    = 1'b0;
        fft_done = 1'b0;
        clear_mem();

        set_vec(0, "single23",  23, 1000, 0,   -1, 0, 0,     -1, 0, 0,
                23, 32'd1000000);
        set_vec(1, "tie10_40",  10, 300, -400, 40, 300, -400, -1, 0, 0,
                10, 32'd250000);
        set_vec(2, "dc_mirror", 0, 32767, 0,   300, 20000, 0, 100, 50, 50,
                100, 32'd5000);
        set_vec(3, "min_bin",   1, -7, 24,     2, 24, -7,    -1, 0, 0,
                1, 32'd625);
        set_vec(4, "all_zero",  -1, 0, 0,      -1, 0, 0,     -1, 0, 0,
                1, 32'd0);
        set_vec(5, "max255",    255, -32768, -32768, 256, 32767, 32767,
                -1, 0, 0, 255, 32'h80000000);

        repeat (3) @(negedge clk);
        chk("rst_adr", 32'(rd_adr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pv", 32'({peak_valid, frame_release}), 32'd0);
        chk("rst_bin", 32'(peak_bin), 32'd0);
        chk("rst_mag", peak_mag, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            if (v != 0) quiesce();
            clear_mem();
            for (int j = 0; j < 3; j++)
                set_bin(vecs[v].idx[j], vecs[v].re[j], vecs[v].im[j]);
            run_frame(vecs[v].name, vecs[v].exp_bin, vecs[v].exp_mag);
        end

        // fft_done stays high after the last table frame: no retrigger
        cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (peak_valid) cnt++;
        end
        chk("held_no_retrig", 32'(cnt), 32'd0);
        chk("held_bin", 32'(peak_bin), 32'd255);

        // Abort by dropping fft_done mid-scan
        quiesce();
        clear_mem();
        set_bin(77, 2000, 0);
        start_scan("abort");
        repeat (100) @(posedge clk);
        @(negedge clk);
        fft_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_adr", 32'(rd_adr), 32'd0);
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (peak_valid || frame_release) cnt++;
        end
        chk("abort_no_pv", 32'(cnt), 32'd0);
        chk("abort_bin_held", 32'(peak_bin), 32'd255);
        chk("abort_mag_held", peak_mag, 32'h80000000);

        // Asynchronous reset mid-scan clears everything at once
        quiesce();
        start_scan("rstmid");
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        fft_done = 1'b0;
        #1;
        chk("rstmid_adr", 32'(rd_adr), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_pv", 32'({peak_valid, frame_release}), 32'd0);
        chk("rstmid_bin", 32'(peak_bin), 32'd0);
        chk("rstmid_mag", peak_mag, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (peak_valid) cnt++;
        end
        chk("rstmid_no_pv", 32'(cnt), 32'd0);
        run_frame("post_rst", 77, 32'd4000000);

`ifdef PEAK_THRESH_EN
        quiesce();
        clear_mem();
        set_bin(50, 1000, 0);
        threshold = 32'd2000000;
        run_frame("thr_hi", 0, 32'd1000000);
        quiesce();
        threshold = 32'd500000;
        run_frame("thr_lo", 50, 32'd1000000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_peak_finder.md
# fft_peak_finder

Post-FFT spectral peak search for the tuner datapath. Sits directly downstream of the 512-point FFT core. On each completed transform it walks the result RAM through the FFT's shared sample-index port, computes re²+im² per bin over the positive-frequency half, and reports the bin with the largest magnitude. It then issues a one-cycle release pulse so the top level can re-arm the FFT for the next frame.

## Interface
Parameters:
- bit_width, 16, width of each real/imag component (signed two's complement)
- M, 9, log2 of FFT length
- N, 512, FFT length; scan covers bins MIN_BIN..N/2-1
- MIN_BIN, 1, first bin searched (excludes DC); must satisfy 0 ≤ MIN_BIN < N/2
- RD_LAT, 1, cycles from rd_adr change to matching wd at the input

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- fft_done  input  1  FFT done flag (level, stays high until FFT is reset)
- wd  input  2*bit_width  FFT result word: real in [2*bit_width-1:bit_width], imag in [bit_width-1:0]
- rd_adr  output  M  bin index presented to the FFT readout port
- busy  output  1  high in SCAN and DRAIN
- peak_valid  output  1  one-cycle pulse: peak_bin/peak_mag updated
- peak_bin  output  M  index of the largest-magnitude bin (held between reports)
- peak_mag  output  2*bit_width  unsigned re²+im² of peak_bin (held)
- frame_release  output  1  one-cycle pulse, coincident with peak_valid; top level uses it to reset and re-arm the FFT

## Operation
- FSM states: IDLE, SCAN, DRAIN, REPORT.
- IDLE:
  - rd_adr = 0.
  - Move to SCAN on a rising edge of fft_done. A registered previous value is used for edge detection, so a level held high never retriggers.
- SCAN:
  - rd_adr starts at MIN_BIN and increments by 1 per cycle through N/2-1.
  - After N/2-1 has been presented, move to DRAIN.
  - Bin count L = N/2 - MIN_BIN.
- DRAIN: hold rd_adr, wait RD_LAT+2 cycles for the pipeline to empty, then move to REPORT.
- REPORT: load peak_bin/peak_mag from the running max, pulse peak_valid and frame_release, then return to IDLE.
- Magnitude pipeline:
  - Stage 1: signed re*re and im*im, each 2*bit_width bits, registered.
  - Stage 2: unsigned sum, 2*bit_width bits, registered.
  - Maximum sum is 2·(2^(2*bit_width-2)) = 2^(2*bit_width-1), so the sum never overflows.
  - A bin-index tag is delayed alongside the data so each magnitude is paired with its own bin.
- Running max:
  - Cleared to magnitude 0, bin MIN_BIN on SCAN entry.
  - Updated only on strictly greater magnitude, so ties keep the lowest bin.
- Abort: if fft_done falls during SCAN or DRAIN, return to IDLE immediately. No peak_valid or frame_release is issued, and outputs keep their previous report.
- Bins ≥ N/2 (mirror image) are never read.

## Timing
- Reset values:
  - rd_adr = 0, busy = 0, peak_valid = 0, frame_release = 0.
  - peak_bin = 0, peak_mag = 0.
  - FSM in IDLE, running max cleared, edge-detect register = 0.
- Reset is asynchronous and may occur mid-scan. All state clears, and the next report needs a fresh fft_done rising edge after reset release.
- Trigger latency: if fft_done is first sampled high at edge k, SCAN is entered at edge k+1 with rd_adr = MIN_BIN.
- From SCAN entry, peak_valid is high exactly L + RD_LAT + 2 cycles later. With defaults, L = 255 and peak_valid occurs at cycle 258.
- peak_bin/peak_mag change only on the peak_valid cycle.
- busy deasserts in the same cycle that peak_valid asserts.
- Throughput: one bin per cycle, no stalls.

## Configuration
- PEAK_THRESH_EN defined:
  - Adds input port threshold (2*bit_width, unsigned).
  - In REPORT, if the running max < threshold, peak_bin reports 0 (meaning "no pitch"). peak_mag still reports the true maximum.
- PEAK_THRESH_EN undefined: no threshold port; the maximum bin is always reported.

## Test plan
- Bin 23 = (1000, 0), all others 0, pulse fft_done → peak_valid 258 cycles after SCAN entry with peak_bin=23, peak_mag=1000000, frame_release in the same cycle.
- Bins 10 and 40 both (300, -400), others 0 → peak_bin=10, peak_mag=250000 (tie resolves to lower bin).
- Bin 0 = (32767, 0), bin 300 = (20000, 0), bin 100 = (50, 50), others 0 → peak_bin=100, peak_mag=5000 (DC and mirror half ignored).
- Bin 255 = (-32768, -32768) → peak_mag=0x80000000, peak_bin=255; hold fft_done high for 1000 further cycles → no second peak_valid.
- Drop fft_done at SCAN cycle 100 → FSM returns to IDLE, rd_adr=0, no peak_valid, previous peak_bin/peak_mag unchanged. Repeat the test with reset asserted mid-scan → all outputs 0 immediately.
- With PEAK_THRESH_EN, threshold=2000000, single bin 50 = (1000, 0) → peak_bin=0, peak_mag=1000000. With threshold=500000 → peak_bin=50.
